// File: rtl/booth_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : booth_sequencer
// Purpose  : Sequential radix-2 Booth multiplier controller. It performs one
//            Booth step per CALC cycle using an external combinational
//            adder-subtractor. It produces a signed 2*WIDTH-bit product after
//            WIDTH iterations.
// Ports    : clk          - rising-edge clock
//            rst_n        - synchronous active-low reset
//            start        - begin a multiply (sampled only in IDLE)
//            multiplicand - signed M, captured on accepted start
//            multiplier   - signed Q, captured on accepted start
//            add_a        - adder operand, always the accumulator A
//            add_b        - adder operand: M, ~M or 0
//            add_cin      - adder carry-in, 1 for subtract
//            add_sum      - sum returned by the external adder
//            busy         - high during the WIDTH iteration cycles
//            done         - one-cycle pulse when the product is valid
//            err          - multiplicand was the most negative value
//            product      - registered signed product {A,Q}
// Revision : 1.0 - initial release
// ============================================================================
module booth_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CW-1:0]    c_LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [CW-1:0]      r_count;
    logic               r_err;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_cin;
    logic               w_busy;
    logic               w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Booth decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_add_b     = '0;
        w_add_cin   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_CALC;
                end
            end
            c_CALC: begin
                w_busy = 1'b1;
                // Subtraction is ~M with carry-in 1; the adder carry-out is
                // dropped, so A stays modulo 2^WIDTH.
                case ({r_q[0], r_qm1})
                    2'b01: w_add_b = r_m;
                    2'b10: begin
                        w_add_b   = ~r_m;
                        w_add_cin = 1'b1;
                    end
                    default: w_add_b = '0;
                endcase
                if (r_count == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, Booth shift, product latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a       <= '0;
                        r_m       <= multiplicand;
                        r_q       <= multiplier;
                        r_qm1     <= 1'b0;
                        r_count   <= '0;
                        r_err     <= (multiplicand == c_MIN_NEG);
                        r_product <= '0;
                    end
                end
                c_CALC: begin
                    // Arithmetic shift right of {sum, Q, q_m1}.
                    r_a     <= {add_sum[WIDTH-1], add_sum[WIDTH-1:1]};
                    r_q     <= {add_sum[0], r_q[WIDTH-1:1]};
                    r_qm1   <= r_q[0];
                    r_count <= r_count + 1'b1;
                    // The last step writes the shifted result straight into
                    // the product register so it is valid during DONE.
                    if (r_count == c_LAST) begin
                        r_product <= {add_sum[WIDTH-1], add_sum, r_q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a   = r_a;
    assign add_b   = w_add_b;
    assign add_cin = w_add_cin;
    assign busy    = w_busy;
    assign done    = w_done;
    assign err     = r_err;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_sequencer
// Purpose  : Directed self-checking bench for booth_sequencer. An ideal
//            WIDTH-bit adder closes the add_a/add_b/add_cin -> add_sum loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_sequencer;

    localparam int WIDTH = 64;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    booth_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .product      (product)
    );

    // External ripple adder-subtractor, carry-out discarded.
    assign add_sum = add_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full multiply: start accepted at the posedge between the first two
    // negedges; busy must hold for 64 cycles, then done with the product.
    task automatic do_mul(input string name, input logic [WIDTH-1:0] m,
                          input logic [WIDTH-1:0] q,
                          input logic [2*WIDTH-1:0] exp_p, input logic exp_e,
                          input logic chk_p);
        int bad_busy;
        @(negedge clk);
        start = 1'b1; multiplicand = m; multiplier = q;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (product !== '0 || err !== exp_e) begin
            n_bad++;
            $display("FAIL %s_load: product=%h err=%b, required product=0 err=%b", name, product, err, exp_e);
        end
        bad_busy = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_bad++;
            $display("FAIL %s_busy: %0d bad cycles of 64, required 0", name, bad_busy);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== exp_e) begin
            n_bad++;
            $display("FAIL %s_done: done=%b busy=%b err=%b, required 1 0 %b", name, done, busy, err, exp_e);
        end
        if (chk_p) begin
            n_cmp++;
            if (product !== exp_p) begin
                n_bad++;
                $display("FAIL %s_product: got %h, required %h", name, product, exp_p);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || product !== (chk_p ? exp_p : product) || err !== exp_e) begin
            n_bad++;
            $display("FAIL %s_hold: done=%b product=%h err=%b, required done=0 product held err=%b", name, done, product, err, exp_e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; multiplicand = 64'd3; multiplier = 64'd5;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || product !== '0 ||
            add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b product=%h add_a=%h add_b=%h cin=%b, required all 0",
                     busy, done, err, product, add_a, add_b, add_cin);
        end
        // First edge with rst_n=1 must accept the held start.
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_start: busy=%b, required 1", busy);
        end
        // First step for Q=5, q_m1=0 is a subtract: add_b=~3, cin=1.
        n_cmp++;
        if (add_b !== ~64'd3 || add_cin !== 1'b1) begin
            n_bad++;
            $display("FAIL first_booth_step: add_b=%h cin=%b, required %h 1", add_b, add_cin, ~64'd3);
        end
        repeat (66) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 128'd15 || add_b !== '0 || add_cin !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_first: busy=%b done=%b product=%h add_b=%h cin=%b, required 0 0 f 0 0",
                     busy, done, product, add_b, add_cin);
        end
    endtask

    task automatic test_products();
        do_mul("pos", 64'd3, 64'd5, 128'h0000000000000000_000000000000000F, 1'b0, 1'b1);
        do_mul("neg", -64'sd3, 64'd5, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFF1, 1'b0, 1'b1);
        do_mul("qmin", 64'd1, 64'h8000000000000000, 128'hFFFFFFFFFFFFFFFF_8000000000000000, 1'b0, 1'b1);
        do_mul("max", 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 128'h3FFFFFFFFFFFFFFF_0000000000000001, 1'b0, 1'b1);
        do_mul("negneg", -64'sd7, -64'sd6, 128'd42, 1'b0, 1'b1);
    endtask

    task automatic test_err();
        do_mul("err", 64'h8000000000000000, 64'd2, '0, 1'b1, 1'b0);
        // Next accepted start clears err.
        do_mul("err_clear", 64'd2, 64'd9, 128'd18, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_start();
        int done_at;
        @(negedge clk);
        start = 1'b1; multiplicand = 64'd3; multiplier = 64'd5;
        @(negedge clk);
        start = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 70; i++) begin
            if (i == 10) begin
                start = 1'b1; multiplicand = 64'd7; multiplier = 64'd7;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1 && done_at < 0) done_at = i;
            @(negedge clk);
            if (done === 1'b1 && done_at < 0) begin
                done_at = i + 1;
                n_cmp++;
                if (product !== 128'd15) begin
                    n_bad++;
                    $display("FAIL ignore_product: got %h, required f", product);
                end
            end
        end
        n_cmp++;
        if (done_at != 65) begin
            n_bad++;
            $display("FAIL ignore_timing: done at cycle %0d, required 65", done_at);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        start = 1'b1; multiplicand = -64'sd3; multiplier = 64'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: busy=%b done=%b product=%h err=%b, required all 0", busy, done, product, err);
        end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: %0d active cycles, required 0", pulses);
        end
        do_mul("after_abort", 64'd11, 64'd13, 128'd143, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; multiplicand = 64'd3; multiplier = 64'd5;
        repeat (65) @(negedge clk);
        // Switch operands so the second run is distinguishable.
        multiplicand = 64'd4; multiplier = 64'd6;
        n_cmp++;
        if (done !== 1'b1 || product !== 128'd15) begin
            n_bad++;
            $display("FAIL b2b_first: done=%b product=%h, required 1 f", done, product);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || product !== '0) begin
            n_bad++;
            $display("FAIL b2b_restart: busy=%b product=%h, required 1 0", busy, product);
        end
        repeat (64) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || product !== 128'd24) begin
            n_bad++;
            $display("FAIL b2b_second: done=%b product=%h, required 1 18", done, product);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        test_reset();
        test_products();
        test_err();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
